// File: rtl/piso_15_pkg.sv
// Shared BCH codeword definitions used by the serializer and its SIPO peer.
package piso_15_pkg;

  // BCH(15,k) codeword length.
  localparam int BCH_N = 15;

  // Serializer control states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_15.sv
// Parallel-in serial-out converter for BCH codewords.
// A word is taken through a valid/ready handshake and sent one bit per clock,
// LSB first. A new word can be taken on the last-bit cycle, so there is no gap
// between words. A shared hold freezes everything in lockstep with the SIPO.
module piso_15
  import piso_15_pkg::*;
#(
  parameter int WIDTH = BCH_N
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] par_in_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             ser_last_o,
  output logic             busy_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             at_last;
  logic             accept;

  assign at_last = (cnt_q == LAST);

  // Ready when idle, or on the last bit of a word so the next one follows
  // without a gap. Reset and hold both refuse new words.
  assign load_ready_o = !reset_i && !hold_i &&
                        ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && at_last));
  assign accept       = load_valid_i && load_ready_o;

  assign ser_out_o   = shreg_q[0];
  assign ser_valid_o = (state_q == ST_SHIFT) && !hold_i;
  assign ser_last_o  = ser_valid_o && at_last;
  assign busy_o      = (state_q == ST_SHIFT);

  // Next-state: load, shift, reload back-to-back or retire; hold freezes all.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = par_in_i;
            cnt_d   = '0;
          end
        end
        ST_SHIFT: begin
          if (!at_last) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
          end else if (accept) begin
            shreg_d = par_in_i;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset that discards any word in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_15.sv
// Directed bench for piso_15 with a behavioural SIPO for the loopback phase.
module tb_piso_15;

  logic        clk = 1'b0;
  logic        reset, hold, load_valid;
  logic [14:0] par_in;
  logic        load_ready, ser_out, ser_valid, ser_last, busy;

  int nchk  = 0;
  int nfail = 0;

  piso_15 dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .hold_i       (hold),
    .par_in_i     (par_in),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .ser_out_o    (ser_out),
    .ser_valid_o  (ser_valid),
    .ser_last_o   (ser_last),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one valid bit of a word at position k.
  task automatic chk_bit(input string tag, input logic [14:0] w, input int k);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
    chk({tag, "_bit"},   32'(ser_out),   32'(w[k]));
    chk({tag, "_last"},  32'(ser_last),  32'(k == 14));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_last"},  32'(ser_last),  32'd0);
  endtask

  initial begin
    logic [14:0] w, w2, sipo, asm_w;
    logic [14:0] sent[$];
    int          words_ok;
    int          guard;

    // ---- reset with load_valid high ----
    reset = 1'b1; hold = 1'b0; load_valid = 1'b1; par_in = 15'h7FFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_ready", 32'(load_ready), 32'd0);
      chk("rst_valid", 32'(ser_valid),  32'd0);
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_out",   32'(ser_out),    32'd0);
      tick();
    end
    reset = 1'b0; load_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    chk_idle("post_rst");
    tick();

    // ---- single word; par_in changed after accept must not matter ----
    w = 15'h4B35;
    par_in = w; load_valid = 1'b1;
    #1;
    chk("single_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0; par_in = 15'h0000;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk_bit("single", w, k);
      chk("single_busy", 32'(busy), 32'd1);
      tick();
    end
    #1;
    chk_idle("single_end");
    tick();

    // ---- back-to-back words, load_valid held high ----
    w = 15'h7FFF; w2 = 15'h0001;
    par_in = w; load_valid = 1'b1;
    tick();
    par_in = w2;
    for (int k = 0; k < 30; k++) begin
      if (k == 15) load_valid = 1'b0;
      #1;
      chk_bit("b2b", (k < 15) ? w : w2, k % 15);
      if (k == 14) chk("b2b_ready_on_last", 32'(load_ready), 32'd1);
      if (k == 3)  chk("b2b_ready_mid",     32'(load_ready), 32'd0);
      tick();
    end
    #1;
    chk_idle("b2b_end");
    tick();

    // ---- hold for 4 cycles with bit 5 on the line; 19-cycle span ----
    w = 15'h2AAA;
    par_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 19; i++) begin
      hold = (i >= 5 && i <= 8);
      #1;
      if (hold) begin
        chk("hold_valid", 32'(ser_valid),  32'd0);
        chk("hold_out",   32'(ser_out),    32'(w[5]));
        chk("hold_busy",  32'(busy),       32'd1);
        chk("hold_ready", 32'(load_ready), 32'd0);
      end else begin
        chk_bit("hold", w, (i < 5) ? i : i - 4);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    chk_idle("hold_end");
    tick();

    // ---- hold on the last bit: neither reloaded nor retired ----
    w = 15'h4001; w2 = 15'h0006;
    par_in = w; load_valid = 1'b1;
    tick();
    par_in = w2;
    for (int k = 0; k < 14; k++) tick();
    hold = 1'b1;
    #1;
    chk("holdlast_ready", 32'(load_ready), 32'd0);
    chk("holdlast_valid", 32'(ser_valid),  32'd0);
    tick(); tick();
    #1;
    chk("holdlast_busy", 32'(busy),    32'd1);
    chk("holdlast_out",  32'(ser_out), 32'(w[14]));
    hold = 1'b0;
    #1;
    chk_bit("holdlast", w, 14);
    chk("holdlast_reload_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk_bit("holdlast_w2", w2, k);
      tick();
    end
    #1;
    chk_idle("holdlast_end");
    tick();

    // ---- reset mid-word at bit 7, then a fresh word ----
    w = 15'h7FFE;
    par_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(load_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk_idle("midrst_after");
    chk("midrst_out", 32'(ser_out), 32'd0);
    tick();
    w = 15'h6C93;
    par_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk_bit("midrst_new", w, k);
      tick();
    end
    #1;
    chk_idle("midrst_end");
    tick();

    // ---- loopback against a behavioural SIPO with random hold ----
    sipo = '0; words_ok = 0;
    par_in = 15'($urandom); load_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 3) == 0);
      #1;
      if (ser_valid) begin
        asm_w = {ser_out, sipo[14:1]};
        sipo  = asm_w;
        if (ser_last) begin
          if (sent.size() == 0) begin
            chk("loop_underflow", 32'(sent.size()), 32'd1);
          end else begin
            chk("loop_word", 32'(asm_w), 32'(sent.pop_front()));
            words_ok++;
          end
        end
      end
      if (load_valid && load_ready) begin
        sent.push_back(par_in);
        tick();
        par_in = 15'($urandom);
      end else begin
        tick();
      end
    end
    // Drain: stop loading, release hold, finish the word in flight.
    load_valid = 1'b0; hold = 1'b0;
    guard = 0;
    #1;
    while (busy && guard < 40) begin
      if (ser_valid) begin
        asm_w = {ser_out, sipo[14:1]};
        sipo  = asm_w;
        if (ser_last && sent.size() != 0) begin
          chk("loop_word", 32'(asm_w), 32'(sent.pop_front()));
          words_ok++;
        end
      end
      tick();
      #1;
      guard++;
    end
    chk("loop_drain_timeout", 32'(guard < 40), 32'd1);
    chk("loop_leftover", 32'(sent.size()), 32'd0);
    chk("loop_enough_words", 32'(words_ok > 10), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
